// File: rtl/extio_arbiter.sv
// Round-robin arbiter serialising the core (0) and debug (1) requesters onto the ExtIO
// peripheral bus. Define EXTIO_TIMEOUT_EN to enable the ISSUE/WAIT watchdog.
module extio_arbiter #(
    parameter int TimeoutCycles = 1024
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [1:0][63:0] req_addr_i,
    input  logic [1:0]       req_we_i,
    input  logic [1:0][63:0] req_wdata_i,
    input  logic [1:0][7:0]  req_be_i,
    output logic [1:0]       rsp_valid_o,
    output logic [63:0]      rsp_rdata_o,
    output logic             rsp_err_o,
    output logic [5:0]       p_sel_o,
    output logic             p_valid_o,
    input  logic             p_ready_i,
    output logic [63:0]      p_addr_o,
    output logic             p_we_o,
    output logic [63:0]      p_wdata_o,
    output logic [7:0]       p_be_o,
    input  logic             p_rsp_valid_i,
    input  logic [63:0]      p_rdata_i,
    input  logic             p_err_i,
    output logic             timeout_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t      state_q, state_next;
    logic        grant_q;
    logic        last_q;
    logic [23:0] addr_q;
    logic        we_q;
    logic [63:0] wdata_q;
    logic [7:0]  be_q;
    logic [5:0]  sel_q;
    logic [63:0] rdata_q;
    logic        err_q;

    logic        any_req;
    logic        grant_sel;
    logic [5:0]  dec_sel;
    logic        timeout_hit;

    // One-hot select: [0]HID [1]GPIO [2]Ethernet [3]SPI [4]UART [5]BOOT; zero means miss.
    function automatic logic [5:0] decode(input logic [63:0] addr);
        logic [5:0] sel;
        sel = 6'b0;
        if (addr[63:32] == 32'b0 && addr[23:16] == 8'h00) begin
            case (addr[31:24])
                8'h40:   sel = 6'b100000;
                8'h41:   sel = 6'b010000;
                8'h42:   sel = 6'b001000;
                8'h43:   sel = 6'b000100;
                8'h44:   sel = 6'b000010;
                default: sel = 6'b000000;
            endcase
        end
        if (addr[63:24] == 40'h45 && addr[23:20] == 4'h0) begin
            sel = 6'b000001;
        end
        return sel;
    endfunction

    always_comb begin
        any_req     = |req_valid_i;
        // last_q records the previous grant, so contention goes to the other requester
        grant_sel   = (&req_valid_i) ? ~last_q : req_valid_i[1];
        dec_sel     = decode(req_addr_i[grant_sel]);
        state_next  = state_q;
        req_ready_o = 2'b00;
        rsp_valid_o = 2'b00;
        rsp_rdata_o = 64'b0;
        rsp_err_o   = 1'b0;
        p_valid_o   = 1'b0;
        p_sel_o     = 6'b0;
        p_addr_o    = 64'b0;
        p_we_o      = 1'b0;
        p_wdata_o   = 64'b0;
        p_be_o      = 8'b0;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_next = (|dec_sel) ? ISSUE : RESP;
                    if (!rst_i) begin
                        req_ready_o[grant_sel] = 1'b1;
                    end
                end
            end
            ISSUE: begin
                p_valid_o = 1'b1;
                p_sel_o   = sel_q;
                p_addr_o  = {40'b0, addr_q};
                p_we_o    = we_q;
                p_wdata_o = wdata_q;
                p_be_o    = be_q;
                if (timeout_hit) begin
                    state_next = RESP;
                end else if (p_ready_i) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                p_sel_o = sel_q;
                if (p_rsp_valid_i || timeout_hit) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                rsp_valid_o[grant_q] = 1'b1;
                rsp_rdata_o          = rdata_q;
                rsp_err_o            = err_q;
                state_next           = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= 24'b0;
            we_q    <= 1'b0;
            wdata_q <= 64'b0;
            be_q    <= 8'b0;
            sel_q   <= 6'b0;
            rdata_q <= 64'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_next;
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q <= grant_sel;
                        addr_q  <= req_addr_i[grant_sel][23:0];
                        we_q    <= req_we_i[grant_sel];
                        wdata_q <= req_wdata_i[grant_sel];
                        be_q    <= req_be_i[grant_sel];
                        sel_q   <= dec_sel;
                        rdata_q <= 64'b0;
                        err_q   <= ~|dec_sel;
                    end
                end
                ISSUE: begin
                    if (timeout_hit) begin
                        rdata_q <= 64'b0;
                        err_q   <= 1'b1;
                    end
                end
                WAIT: begin
                    if (p_rsp_valid_i) begin
                        rdata_q <= p_rdata_i;
                        err_q   <= p_err_i;
                    end else if (timeout_hit) begin
                        rdata_q <= 64'b0;
                        err_q   <= 1'b1;
                    end
                end
                RESP: last_q <= grant_q;
                default: ;
            endcase
        end
    end

`ifdef EXTIO_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q;
    logic            timeout_q;

    // Counter sits at zero outside ISSUE/WAIT, so it is clear on the first ISSUE cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_hit && !(state_q == WAIT && p_rsp_valid_i);
            if (state_q == ISSUE || state_q == WAIT) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign timeout_hit = (state_q == ISSUE || state_q == WAIT) &&
                         (cnt_q == CntW'(TimeoutCycles - 1));
    assign timeout_o   = timeout_q;
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

endmodule

// File: tb/tb_extio_arbiter.sv
// Scoreboard bench for extio_arbiter: expected responses are queued at accept time and
// checked by a response monitor; each task checks its own scenario inline.
module tb_extio_arbiter;

    localparam logic [63:0] RespData = 64'h0000_0000_DEAD_BEEF;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b1;
    logic [1:0]       req_valid_i = '0;
    logic [1:0]       req_ready_o;
    logic [1:0][63:0] req_addr_i = '0;
    logic [1:0]       req_we_i = '0;
    logic [1:0][63:0] req_wdata_i = '0;
    logic [1:0][7:0]  req_be_i = '0;
    logic [1:0]       rsp_valid_o;
    logic [63:0]      rsp_rdata_o;
    logic             rsp_err_o;
    logic [5:0]       p_sel_o;
    logic             p_valid_o;
    logic             p_ready_i = 1'b1;
    logic [63:0]      p_addr_o;
    logic             p_we_o;
    logic [63:0]      p_wdata_o;
    logic [7:0]       p_be_o;
    logic             p_rsp_valid_i;
    logic [63:0]      p_rdata_i;
    logic             p_err_i;
    logic             timeout_o;

    logic        rsp_en = 1'b1;
    logic        rsp_pulse = 1'b0;
    logic [63:0] model_rdata = '0;
    logic        inject_rsp = 1'b0;
    logic [63:0] inj_rdata = '0;

    typedef struct {
        logic [1:0]  vec;
        logic [63:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   pvalid_cnt = 0;

    always #5 clk_i = ~clk_i;

    extio_arbiter #(.TimeoutCycles(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_we_i(req_we_i),
        .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .p_sel_o(p_sel_o), .p_valid_o(p_valid_o), .p_ready_i(p_ready_i),
        .p_addr_o(p_addr_o), .p_we_o(p_we_o), .p_wdata_o(p_wdata_o), .p_be_o(p_be_o),
        .p_rsp_valid_i(p_rsp_valid_i), .p_rdata_i(p_rdata_i), .p_err_i(p_err_i),
        .timeout_o(timeout_o)
    );

    // Zero-wait peripheral: answers the cycle after a handshake with RespData ^ wdata.
    always @(posedge clk_i) begin
        if (p_valid_o && p_ready_i && rsp_en) begin
            rsp_pulse   <= 1'b1;
            model_rdata <= RespData ^ p_wdata_o;
        end else begin
            rsp_pulse <= 1'b0;
        end
    end

    assign p_rsp_valid_i = rsp_pulse | inject_rsp;
    assign p_rdata_i     = inject_rsp ? inj_rdata : model_rdata;
    assign p_err_i       = 1'b0;

    task automatic monitor_rsp();
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (p_valid_o) pvalid_cnt++;
                checks++;
                if (rsp_valid_o != 2'b00) begin
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL rsp_unexpected got vld=%b required none", rsp_valid_o);
                    end else begin
                        e = sb.pop_front();
                        if (rsp_valid_o !== e.vec || rsp_rdata_o !== e.rdata || rsp_err_o !== e.err) begin
                            errors++;
                            $display("FAIL rsp_data got vld=%b rdata=%h err=%b required vld=%b rdata=%h err=%b",
                                     rsp_valid_o, rsp_rdata_o, rsp_err_o, e.vec, e.rdata, e.err);
                        end
                    end
                end else if (rsp_rdata_o !== 64'b0 || rsp_err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL rsp_idle got rdata=%h err=%b required 0/0", rsp_rdata_o, rsp_err_o);
                end
            end
        end
    endtask

    // Presents one request, queues its expected response on accept, and returns
    // just after the accepting edge.
    task automatic drive_req(input int idx, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic we, input logic [63:0] exp_rdata, input logic exp_err);
        bit   got;
        exp_t e;
        got = 1'b0;
        @(negedge clk_i);
        req_addr_i[idx]  = addr;
        req_wdata_i[idx] = wdata;
        req_we_i[idx]    = we;
        req_be_i[idx]    = 8'hFF;
        req_valid_i[idx] = 1'b1;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (req_ready_o[idx]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        if (got) begin
            e.vec   = (idx == 0) ? 2'b01 : 2'b10;
            e.rdata = exp_rdata;
            e.err   = exp_err;
            sb.push_back(e);
            @(posedge clk_i);
            #1;
        end else begin
            checks++;
            errors++;
            $display("FAIL req_accept got ready=0 required 1 (idx %0d)", idx);
        end
        req_valid_i[idx] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 100 && sb.size() != 0; c++) @(negedge clk_i);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain got pending=%0d required 0", sb.size());
        end
        @(negedge clk_i);
    endtask

    task automatic apply_reset();
        @(negedge clk_i);
        rst_i       = 1'b1;
        req_valid_i = 2'b00;
        inject_rsp  = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        req_addr_i[0] = 64'h4400_0000;
        req_addr_i[1] = 64'h4400_0000;
        req_valid_i   = 2'b11;
        #2;
        checks++;
        if (req_ready_o !== 2'b00) begin
            errors++; $display("FAIL reset_ready got %b required 00", req_ready_o);
        end
        checks++;
        if ({p_valid_o, p_sel_o, p_addr_o, p_we_o, p_wdata_o, p_be_o} !== '0) begin
            errors++; $display("FAIL reset_pbus got valid=%b sel=%b addr=%h required 0", p_valid_o, p_sel_o, p_addr_o);
        end
        checks++;
        if ({rsp_valid_o, rsp_rdata_o, rsp_err_o, timeout_o} !== '0) begin
            errors++; $display("FAIL reset_rsp got vld=%b rdata=%h err=%b to=%b required 0", rsp_valid_o, rsp_rdata_o, rsp_err_o, timeout_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        checks++;
        if (req_ready_o !== 2'b01) begin
            errors++; $display("FAIL reset_rr_ptr got %b required 01", req_ready_o);
        end
        req_valid_i = 2'b00;
    endtask

    task automatic test_single_read();
        drive_req(0, 64'h4100_0008, 64'h0, 1'b0, RespData, 1'b0);
        @(negedge clk_i);
        checks++;
        if (p_valid_o !== 1'b1 || p_sel_o !== 6'b010000 || p_addr_o !== 64'h8) begin
            errors++; $display("FAIL read_issue got valid=%b sel=%b addr=%h required 1/010000/8", p_valid_o, p_sel_o, p_addr_o);
        end
        @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 2'b00) begin
            errors++; $display("FAIL read_early got %b required 00", rsp_valid_o);
        end
        @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 2'b01 || rsp_rdata_o !== RespData || rsp_err_o !== 1'b0) begin
            errors++; $display("FAIL read_latency got vld=%b rdata=%h err=%b required 01/%h/0", rsp_valid_o, rsp_rdata_o, rsp_err_o, RespData);
        end
        wait_drain();
    endtask

    task automatic test_contention();
        logic [1:0][63:0] wd;
        int   order[4] = '{0, 1, 0, 1};
        int   n;
        int   idx;
        exp_t e;
        apply_reset();
        wd[0] = 64'h0000_0000_0000_1111;
        wd[1] = 64'h2222_0000_0000_0000;
        n = 0;
        @(negedge clk_i);
        req_addr_i  = {64'h4400_0000, 64'h4400_0000};
        req_wdata_i = wd;
        req_valid_i = 2'b11;
        for (int c = 0; c < 200 && n < 4; c++) begin
            #1;
            if (req_ready_o != 2'b00) begin
                idx = req_ready_o[1] ? 1 : 0;
                checks++;
                if (idx != order[n]) begin
                    errors++; $display("FAIL rr_order[%0d] got %0d required %0d", n, idx, order[n]);
                end
                e.vec   = (idx == 0) ? 2'b01 : 2'b10;
                e.rdata = RespData ^ wd[idx];
                e.err   = 1'b0;
                sb.push_back(e);
                n++;
                if (n == 4) begin
                    @(posedge clk_i);
                    #1;
                    req_valid_i = 2'b00;
                end
            end
            @(negedge clk_i);
        end
        req_valid_i = 2'b00;
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL rr_grants got %0d required 4", n);
        end
        wait_drain();
    endtask

    task automatic test_decode_err();
        int pv;
        pv = pvalid_cnt;
        drive_req(1, 64'h4101_0000, 64'h0, 1'b0, 64'h0, 1'b1);
        @(negedge clk_i);
        checks++;
        if (rsp_valid_o !== 2'b10 || rsp_err_o !== 1'b1) begin
            errors++; $display("FAIL decerr_uart got vld=%b err=%b required 10/1", rsp_valid_o, rsp_err_o);
        end
        wait_drain();
        drive_req(1, 64'h4600_0000, 64'h0, 1'b0, 64'h0, 1'b1);
        wait_drain();
        checks++;
        if (pvalid_cnt != pv) begin
            errors++; $display("FAIL decerr_pvalid got %0d cycles required 0", pvalid_cnt - pv);
        end
    endtask

    task automatic test_hid_boundary();
        drive_req(0, 64'h450F_FFF8, 64'h0, 1'b0, RespData, 1'b0);
        @(negedge clk_i);
        checks++;
        if (p_sel_o !== 6'b000001 || p_addr_o !== 64'h000F_FFF8) begin
            errors++; $display("FAIL hid_last got sel=%b addr=%h required 000001/fffff8", p_sel_o, p_addr_o);
        end
        wait_drain();
        drive_req(0, 64'h4510_0000, 64'h0, 1'b0, 64'h0, 1'b1);
        @(negedge clk_i);
        checks++;
        if (p_sel_o !== 6'b0 || p_valid_o !== 1'b0) begin
            errors++; $display("FAIL hid_past got sel=%b valid=%b required 0/0", p_sel_o, p_valid_o);
        end
        wait_drain();
    endtask

    task automatic test_backpressure();
        int bad;
        bad = 0;
        p_ready_i = 1'b0;
        drive_req(0, 64'h4200_0040, 64'h0, 1'b1, RespData, 1'b0);
        req_addr_i[1]  = 64'h4400_0000;
        req_valid_i[1] = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i);
            checks++;
            if (p_valid_o !== 1'b1 || p_sel_o !== 6'b001000 || p_addr_o !== 64'h40 ||
                p_we_o !== 1'b1 || req_ready_o !== 2'b00) begin
                errors++; bad++;
                $display("FAIL stall_hold cycle %0d got valid=%b sel=%b addr=%h ready=%b required 1/001000/40/00",
                         k, p_valid_o, p_sel_o, p_addr_o, req_ready_o);
            end
        end
        req_valid_i[1] = 1'b0;
        p_ready_i      = 1'b1;
        wait_drain();
    endtask

    task automatic test_reset_mid();
        p_ready_i = 1'b0;
        drive_req(1, 64'h4300_0010, 64'h0, 1'b0, RespData, 1'b0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checks++;
        if (p_valid_o !== 1'b0 || p_sel_o !== 6'b0) begin
            errors++; $display("FAIL rstmid_drop got valid=%b sel=%b required 0/0", p_valid_o, p_sel_o);
        end
        sb.delete();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        inj_rdata  = 64'h0BAD_0BAD_0BAD_0BAD;
        inject_rsp = 1'b1;
        @(negedge clk_i);
        inject_rsp = 1'b0;
        repeat (4) @(negedge clk_i);
        checks++;
        if (p_valid_o !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle got valid=%b required 0", p_valid_o);
        end
        req_valid_i = 2'b11;
        #1;
        checks++;
        if (req_ready_o !== 2'b01) begin
            errors++; $display("FAIL rstmid_rr_ptr got %b required 01", req_ready_o);
        end
        req_valid_i = 2'b00;
        p_ready_i   = 1'b1;
        @(negedge clk_i);
    endtask

`ifdef EXTIO_TIMEOUT_EN
    task automatic test_timeout();
        int early;
        early  = 0;
        rsp_en = 1'b0;
        drive_req(0, 64'h4400_0000, 64'h0, 1'b0, 64'h0, 1'b1);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk_i);
            if (k < 17 && (timeout_o !== 1'b0 || rsp_valid_o !== 2'b00)) early++;
        end
        checks++;
        if (timeout_o !== 1'b1 || rsp_valid_o !== 2'b01 || rsp_err_o !== 1'b1 || p_valid_o !== 1'b0) begin
            errors++; $display("FAIL timeout_fire got to=%b vld=%b err=%b pvalid=%b required 1/01/1/0",
                               timeout_o, rsp_valid_o, rsp_err_o, p_valid_o);
        end
        checks++;
        if (early != 0) begin
            errors++; $display("FAIL timeout_early got %0d early cycles required 0", early);
        end
        @(negedge clk_i);
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++; $display("FAIL timeout_pulse got %b required 0", timeout_o);
        end
        inj_rdata  = 64'h1234;
        inject_rsp = 1'b1;
        @(negedge clk_i);
        inject_rsp = 1'b0;
        repeat (3) @(negedge clk_i);
        rsp_en = 1'b1;
        wait_drain();
    endtask
`else
    task automatic test_no_timeout();
        int seen;
        seen   = 0;
        rsp_en = 1'b0;
        drive_req(1, 64'h4000_0100, 64'h0, 1'b0, 64'h1234_5678_9ABC_DEF0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (timeout_o !== 1'b0 || rsp_valid_o !== 2'b00) seen++;
        end
        checks++;
        if (seen != 0 || p_sel_o !== 6'b100000) begin
            errors++; $display("FAIL no_timeout_wait got events=%0d sel=%b required 0/100000", seen, p_sel_o);
        end
        inj_rdata  = 64'h1234_5678_9ABC_DEF0;
        inject_rsp = 1'b1;
        @(negedge clk_i);
        inject_rsp = 1'b0;
        rsp_en     = 1'b1;
        wait_drain();
    endtask
`endif

    initial begin
        fork
            monitor_rsp();
        join_none
        test_reset();
        test_single_read();
        test_contention();
        test_decode_err();
        test_hid_boundary();
        test_backpressure();
        test_reset_mid();
`ifdef EXTIO_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
